// File: rtl/spr_rom_fetch.sv
// ---------------------------------------------------------------------------
// spr_rom_fetch
//
// Sprite graphics ROM fetch unit. Sits between the sprite address generator
// and the SDRAM sprite port. For every accepted fetch it:
//   1. reads a 4-bit decode PROM entry selected by {bank, ca[17:11]},
//   2. permutes the low character-address lines according to the PROM mode,
//   3. looks the resulting 19-bit word address up in a small fully
//      associative line cache, going to SDRAM through a req/ack handshake
//      on a miss,
//   4. converts the chunky pixel word to planar form for the serialiser.
// It also hosts the PROM loader that unpacks 16-bit download words into two
// 4-bit PROM entries.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   ioctl_download   download in progress: blocks fetches, clears the cache
//   dl_we            one-cycle pulse, download word valid
//   dl_addr          download word index (one word = two PROM entries)
//   dl_data          download word, nibbles [3:0] and [11:8] are used
//   fetch_valid      fetch request from the address generator
//   fetch_ready      unit can accept a request this cycle
//   ca, bank         sprite character address and ROM bank, latched on accept
//   sdram_req        SDRAM read request (level, held until ack)
//   sdram_addr       SDRAM word address
//   sdram_ack        one-cycle pulse, sdram_dout valid
//   sdram_dout       SDRAM read data (chunky, BPP bits per pixel)
//   pix_valid        one-cycle pulse, pix_planar holds new data
//   pix_planar       planar pixel data, held until the next pix_valid
// ---------------------------------------------------------------------------
module spr_rom_fetch #(
    parameter int DATA_W    = 32,
    parameter int BPP       = 4,
    parameter int PIX       = 8,
    parameter int PROM_AW   = 8,
    parameter int CACHE_N   = 2,
    parameter int DECODE_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic                 dl_we,
    input  logic [PROM_AW-2:0]   dl_addr,
    input  logic [15:0]          dl_data,
    input  logic                 fetch_valid,
    output logic                 fetch_ready,
    input  logic [17:0]          ca,
    input  logic                 bank,
    output logic                 sdram_req,
    output logic [18:0]          sdram_addr,
    input  logic                 sdram_ack,
    input  logic [DATA_W-1:0]    sdram_dout,
    output logic                 pix_valid,
    output logic [DATA_W-1:0]    pix_planar
);

    localparam int PTR_W     = (CACHE_N > 1) ? $clog2(CACHE_N) : 1;
    localparam int PROM_SIZE = 2 ** PROM_AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_REQ,
        S_OUT
    } state_t;

    typedef enum logic [1:0] {
        L_IDLE,
        L_LO,
        L_HI
    } ld_state_t;

    state_t                state;
    state_t                state_next;
    ld_state_t             ld_state;
    ld_state_t             ld_next;

    logic [17:0]           ca_q;
    logic                  bank_q;
    logic                  accept;

    logic [3:0]            prom [PROM_SIZE];
    logic [3:0]            prom_q;
    logic [PROM_AW-1:0]    prom_idx;
    logic                  prom_we;
    logic [PROM_AW-1:0]    prom_waddr;
    logic [3:0]            prom_wdata;
    logic [PROM_AW-2:0]    ld_addr_q;
    logic [7:0]            ld_data_q;

    logic [2:0]            mode;
    logic [8:0]            dec;
    logic [18:0]           addr19;

    logic [18:0]           tag   [CACHE_N];
    logic [DATA_W-1:0]     cdata [CACHE_N];
    logic [CACHE_N-1:0]    cvalid;
    logic [PTR_W-1:0]      victim;
    logic                  hit;
    logic [DATA_W-1:0]     hit_data;
    logic                  fill_en;

    logic                  unused_bits;

    // Address-line permutation selected by the decode PROM mode. Each row
    // lists the ca bits that land on dec[8] down to dec[0].
    function automatic logic [8:0] permute(input logic [2:0] m, input logic [17:0] a);
        logic [8:0] r;
        case (m)
            3'd0:       r = {a[9], a[8], a[7], a[6], a[5], a[4], a[2], a[1], a[0]};
            3'd1:       r = {a[9], a[8], a[7], a[5], a[6], a[4], a[2], a[1], a[0]};
            3'd2, 3'd3: r = {a[9], a[8], a[7], a[6], a[4], a[2], a[1], a[0], a[5]};
            3'd4:       r = {a[9], a[7], a[8], a[6], a[4], a[2], a[1], a[0], a[5]};
            3'd5, 3'd6: r = {a[9], a[8], a[6], a[4], a[2], a[1], a[0], a[7], a[5]};
            default:    r = {a[8], a[6], a[4], a[2], a[1], a[0], a[9], a[7], a[5]};
        endcase
        return r;
    endfunction

    // Chunky to planar: pixel i occupies bits [i*BPP +: BPP] of the ROM word,
    // plane p collects bit p of every pixel into [p*PIX +: PIX].
    function automatic logic [DATA_W-1:0] to_planar(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int p = 0; p < BPP; p++) begin
            for (int i = 0; i < PIX; i++) begin
                r[p*PIX + i] = d[i*BPP + p];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // PROM loader: one download word becomes two PROM writes on the two
    // cycles after dl_we. Further dl_we pulses are ignored until it is idle
    // again, and dropping ioctl_download abandons a half-written word.
    // ------------------------------------------------------------------
    always_comb begin
        ld_next    = ld_state;
        prom_we    = 1'b0;
        prom_waddr = {ld_addr_q, 1'b0};
        prom_wdata = ld_data_q[3:0];
        case (ld_state)
            L_IDLE: begin
                if (ioctl_download && dl_we) begin
                    ld_next = L_LO;
                end
            end
            L_LO: begin
                prom_we = 1'b1;
                ld_next = L_HI;
            end
            L_HI: begin
                prom_we    = 1'b1;
                prom_waddr = {ld_addr_q, 1'b1};
                prom_wdata = ld_data_q[7:4];
                ld_next    = L_IDLE;
            end
            default: begin
                ld_next = L_IDLE;
            end
        endcase
        if (!ioctl_download) begin
            ld_next = L_IDLE;
            prom_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state  <= L_IDLE;
            ld_addr_q <= '0;
            ld_data_q <= '0;
        end else begin
            ld_state <= ld_next;
            if (ld_state == L_IDLE && ioctl_download && dl_we) begin
                ld_addr_q <= dl_addr;
                ld_data_q <= {dl_data[11:8], dl_data[3:0]};
            end
        end
    end

    // PROM storage is not reset; the read is registered during LOOKUP so the
    // mode is stable for the whole CHECK cycle.
    assign prom_idx = PROM_AW'({bank_q, ca_q[17:11]});

    always_ff @(posedge clk) begin
        if (prom_we) begin
            prom[prom_waddr] <= prom_wdata;
        end
        if (state == S_LOOKUP) begin
            prom_q <= prom[prom_idx];
        end
    end

    // ------------------------------------------------------------------
    // Address decode and cache tag compare, used in CHECK.
    // ------------------------------------------------------------------
    assign mode   = (DECODE_EN != 0) ? prom_q[2:0] : 3'd0;
    assign dec    = permute(mode, ca_q);
    assign addr19 = {bank_q, ca_q[17:10], dec, ca_q[3]};

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < CACHE_N; i++) begin
            if (cvalid[i] && tag[i] == addr19) begin
                hit      = 1'b1;
                hit_data = cdata[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM.
    // ------------------------------------------------------------------
    assign accept = (state == S_IDLE) && fetch_valid && !ioctl_download;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        fetch_ready = 1'b0;
        sdram_req   = 1'b0;
        pix_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                fetch_ready = !ioctl_download;
                if (accept) begin
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_next = S_CHECK;
            end
            S_CHECK: begin
                state_next = hit ? S_OUT : S_REQ;
            end
            S_REQ: begin
                sdram_req = 1'b1;
                if (sdram_ack) begin
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                pix_valid  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // A fill that completes while a download is running would carry data
    // from the old ROM image, so it is dropped rather than cached.
    assign fill_en = (state == S_REQ) && sdram_ack && !ioctl_download;

    // Datapath registers: request latch, SDRAM address, output data and the
    // cache bookkeeping. The download clear comes last so it always wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ca_q       <= '0;
            bank_q     <= 1'b0;
            sdram_addr <= '0;
            pix_planar <= '0;
            cvalid     <= '0;
            victim     <= '0;
        end else begin
            if (accept) begin
                ca_q   <= ca;
                bank_q <= bank;
            end
            if (state == S_CHECK) begin
                sdram_addr <= addr19;
                if (hit) begin
                    pix_planar <= to_planar(hit_data);
                end
            end
            if (state == S_REQ && sdram_ack) begin
                pix_planar <= to_planar(sdram_dout);
            end
            if (fill_en) begin
                cvalid[victim] <= 1'b1;
                if (victim == PTR_W'(CACHE_N - 1)) begin
                    victim <= '0;
                end else begin
                    victim <= victim + 1'b1;
                end
            end
            if (ioctl_download) begin
                cvalid <= '0;
            end
        end
    end

    // Cache tag and data storage; validity is tracked separately above so
    // these arrays need no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag[victim]   <= sdram_addr;
            cdata[victim] <= sdram_dout;
        end
    end

    // PROM bit 3 is spare and only two nibbles of each download word carry data.
    assign unused_bits = ^{prom_q, dl_data[15:12], dl_data[7:4]};

endmodule

// File: tb/tb_spr_rom_fetch.sv
// ---------------------------------------------------------------------------
// tb_spr_rom_fetch
//
// Directed, self-checking bench for spr_rom_fetch. Two instances share all
// inputs: dut decodes through the PROM, dut_nd has the permutation bypassed.
// A table of fetch vectors exercises decode modes, planar conversion and the
// round-robin cache; hand sequences cover the loader, stray acks, reset in
// the middle of an SDRAM request and a download arriving mid-fetch.
// ---------------------------------------------------------------------------
module tb_spr_rom_fetch;

    localparam int DATA_W  = 32;
    localparam int PROM_AW = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                ioctl_download;
    logic                dl_we;
    logic [PROM_AW-2:0]  dl_addr;
    logic [15:0]         dl_data;
    logic                fetch_valid;
    logic [17:0]         ca;
    logic                bank;
    logic                sdram_ack;
    logic [DATA_W-1:0]   sdram_dout;

    logic                fetch_ready,    nd_fetch_ready;
    logic                sdram_req,      nd_sdram_req;
    logic [18:0]         sdram_addr,     nd_sdram_addr;
    logic                pix_valid,      nd_pix_valid;
    logic [DATA_W-1:0]   pix_planar,     nd_pix_planar;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        bank;
        logic [17:0] ca;
        logic        hit;
        logic [18:0] addr;
        logic [18:0] addr_nd;
        logic [31:0] data;
        logic [31:0] planar;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    // Decoding instance.
    spr_rom_fetch #(.DATA_W(32), .BPP(4), .PIX(8), .PROM_AW(8), .CACHE_N(2), .DECODE_EN(1)) dut (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download),
        .dl_we(dl_we), .dl_addr(dl_addr), .dl_data(dl_data),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .ca(ca), .bank(bank),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .sdram_dout(sdram_dout),
        .pix_valid(pix_valid), .pix_planar(pix_planar)
    );

    // Bypass instance: same PROM contents, mode forced to 0.
    spr_rom_fetch #(.DATA_W(32), .BPP(4), .PIX(8), .PROM_AW(8), .CACHE_N(2), .DECODE_EN(0)) dut_nd (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download),
        .dl_we(dl_we), .dl_addr(dl_addr), .dl_data(dl_data),
        .fetch_valid(fetch_valid), .fetch_ready(nd_fetch_ready),
        .ca(ca), .bank(bank),
        .sdram_req(nd_sdram_req), .sdram_addr(nd_sdram_addr),
        .sdram_ack(sdram_ack), .sdram_dout(sdram_dout),
        .pix_valid(nd_pix_valid), .pix_planar(nd_pix_planar)
    );

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one accepted fetch starting at a negedge; returns at the
    // negedge three cycles after the accept cycle (OUT on a hit, REQ on a miss).
    task automatic applyStimulus(input logic b, input logic [17:0] c);
        bank        = b;
        ca          = c;
        fetch_valid = 1'b1;
        @(negedge clk);
        fetch_valid = 1'b0;
        ca          = 18'h3FFFF;
        bank        = ~b;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        while (!fetch_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " fetch_ready"}, 32'(fetch_ready), 32'd1);
    endtask

    task automatic loadWord(input logic [PROM_AW-2:0] a, input logic [15:0] d);
        dl_we   = 1'b1;
        dl_addr = a;
        dl_data = d;
        @(negedge clk);
        dl_we = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic runVector(input string name, input vec_t v);
        waitReady(name);
        applyStimulus(v.bank, v.ca);
        if (v.hit) begin
            checkOutput({name, " hit sdram_req"}, 32'(sdram_req), 32'd0);
            checkOutput({name, " hit pix_valid"}, 32'(pix_valid), 32'd1);
            checkOutput({name, " hit pix_planar"}, pix_planar, v.planar);
        end else begin
            checkOutput({name, " miss sdram_req"}, 32'(sdram_req), 32'd1);
            checkOutput({name, " miss sdram_addr"}, 32'(sdram_addr), 32'(v.addr));
            checkOutput({name, " bypass sdram_addr"}, 32'(nd_sdram_addr), 32'(v.addr_nd));
            checkOutput({name, " miss pix_valid"}, 32'(pix_valid), 32'd0);
            @(negedge clk);
            checkOutput({name, " req held"}, 32'(sdram_req), 32'd1);
            checkOutput({name, " addr held"}, 32'(sdram_addr), 32'(v.addr));
            sdram_ack  = 1'b1;
            sdram_dout = v.data;
            @(negedge clk);
            sdram_ack  = 1'b0;
            sdram_dout = 32'hDEAD_BEEF;
            checkOutput({name, " fill pix_valid"}, 32'(pix_valid), 32'd1);
            checkOutput({name, " fill pix_planar"}, pix_planar, v.planar);
            checkOutput({name, " fill req dropped"}, 32'(sdram_req), 32'd0);
        end
        @(negedge clk);
        checkOutput({name, " pix_valid pulse"}, 32'(pix_valid), 32'd0);
    endtask

    initial begin
        vec_t tmp;
        int   seen;

        // bank, ca, hit, addr, bypass addr, SDRAM data, planar
        vecs[0]  = '{1'b0, 18'h14820, 1'b0, 19'h14802, 19'h14820, 32'h76543210, 32'h00F0CCAA};
        vecs[1]  = '{1'b0, 18'h14820, 1'b1, 19'h0,     19'h0,     32'h0,        32'h00F0CCAA};
        vecs[2]  = '{1'b0, 18'h14048, 1'b0, 19'h14021, 19'h14041, 32'h89ABCDEF, 32'hFF0F3355};
        vecs[3]  = '{1'b1, 18'h01E01, 1'b0, 19'h41C18, 19'h41E02, 32'h11111111, 32'h000000FF};
        vecs[4]  = '{1'b0, 18'h14820, 1'b0, 19'h14802, 19'h14820, 32'h76543210, 32'h00F0CCAA};
        vecs[5]  = '{1'b1, 18'h01E01, 1'b1, 19'h0,     19'h0,     32'h0,        32'h000000FF};
        vecs[6]  = '{1'b0, 18'h14048, 1'b0, 19'h14021, 19'h14041, 32'h89ABCDEF, 32'hFF0F3355};
        vecs[7]  = '{1'b0, 18'h14820, 1'b1, 19'h0,     19'h0,     32'h0,        32'h00F0CCAA};
        vecs[8]  = '{1'b1, 18'h01128, 1'b0, 19'h41083, 19'h41121, 32'hF0F0F0F0, 32'hAAAAAAAA};
        vecs[9]  = '{1'b0, 18'h05490, 1'b0, 19'h05444, 19'h05490, 32'h12345678, 32'h011E66AA};
        vecs[10] = '{1'b0, 18'h05490, 1'b1, 19'h0,     19'h0,     32'h0,        32'h011E66AA};

        reset          = 1'b1;
        ioctl_download = 1'b0;
        dl_we          = 1'b0;
        dl_addr        = '0;
        dl_data        = '0;
        fetch_valid    = 1'b0;
        ca             = '0;
        bank           = 1'b0;
        sdram_ack      = 1'b0;
        sdram_dout     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and a quiet idle period.
        checkOutput("reset fetch_ready", 32'(fetch_ready), 32'd1);
        checkOutput("reset sdram_req", 32'(sdram_req), 32'd0);
        checkOutput("reset sdram_addr", 32'(sdram_addr), 32'd0);
        checkOutput("reset pix_planar", pix_planar, 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pix_valid || sdram_req || !fetch_ready) seen++;
        end
        checkOutput("idle activity", 32'(seen), 32'd0);

        // PROM load: entries 0x28=1, 0x29=2, 0x82=4, 0x83=7, 0x0A=5, 0x0B=0xA.
        ioctl_download = 1'b1;
        @(negedge clk);
        checkOutput("download fetch_ready", 32'(fetch_ready), 32'd0);
        dl_we   = 1'b1;
        dl_addr = 7'h14;
        dl_data = 16'h0201;
        @(negedge clk);
        dl_data = 16'h0707;
        @(negedge clk);
        dl_we = 1'b0;
        repeat (4) @(negedge clk);
        loadWord(7'h41, 16'h0704);
        loadWord(7'h05, 16'h0A05);
        ioctl_download = 1'b0;
        @(negedge clk);
        // Loader must ignore words outside a download.
        dl_we   = 1'b1;
        dl_addr = 7'h05;
        dl_data = 16'h0303;
        @(negedge clk);
        dl_we = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        // SDRAM ack while idle must be ignored.
        sdram_ack  = 1'b1;
        sdram_dout = 32'h0F0F0F0F;
        @(negedge clk);
        sdram_ack = 1'b0;
        checkOutput("stray ack pix_valid", 32'(pix_valid), 32'd0);
        checkOutput("stray ack pix_planar", pix_planar, 32'h011E66AA);
        checkOutput("stray ack fetch_ready", 32'(fetch_ready), 32'd1);

        // Reset in the middle of an SDRAM request.
        applyStimulus(1'b0, 18'h14821);
        checkOutput("rst-mid req", 32'(sdram_req), 32'd1);
        checkOutput("rst-mid addr", 32'(sdram_addr), 32'h14806);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst-mid req dropped", 32'(sdram_req), 32'd0);
        checkOutput("rst-mid fetch_ready", 32'(fetch_ready), 32'd1);
        checkOutput("rst-mid sdram_addr", 32'(sdram_addr), 32'd0);
        checkOutput("rst-mid pix_planar", pix_planar, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        tmp     = vecs[9];
        runVector("post-reset E", tmp);

        // Download raised while a miss is outstanding.
        applyStimulus(1'b0, 18'h14820);
        checkOutput("dl-mid req", 32'(sdram_req), 32'd1);
        ioctl_download = 1'b1;
        @(negedge clk);
        checkOutput("dl-mid fetch_ready", 32'(fetch_ready), 32'd0);
        sdram_ack  = 1'b1;
        sdram_dout = 32'h76543210;
        @(negedge clk);
        sdram_ack = 1'b0;
        checkOutput("dl-mid pix_valid", 32'(pix_valid), 32'd1);
        checkOutput("dl-mid pix_planar", pix_planar, 32'h00F0CCAA);
        @(negedge clk);
        checkOutput("dl idle fetch_ready", 32'(fetch_ready), 32'd0);
        checkOutput("dl idle pix_valid", 32'(pix_valid), 32'd0);
        ioctl_download = 1'b0;
        @(negedge clk);
        tmp = vecs[0];
        runVector("post-dl A", tmp);
        tmp = vecs[9];
        runVector("post-dl E", tmp);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
